panda_top_tb: RTL and testbench



---
 rtl/panda_tb_pkg.sv | 28 ++
 rtl/pcap_fifo.sv | 59 +++++
 rtl/panda_top_tb.sv | 177 +++++++++++++++++
 tb/tb_panda_top_tb.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/panda_tb_pkg.sv
// Shared constants for the PandA carrier harness: register map, IRQ flag bits,
// default depths and the PCAP arm state type.
package panda_tb_pkg;

   localparam int DEF_TABLE_DEPTH = 32;
   localparam int DEF_BUF_DEPTH   = 32;
   localparam int DEF_AW          = 8;

   localparam logic [7:0] ADDR_PGEN_TABLE  = 8'h00;
   localparam logic [7:0] ADDR_PGEN_RESET  = 8'h01;
   localparam logic [7:0] ADDR_PGEN_REPEAT = 8'h02;
   localparam logic [7:0] ADDR_FRAME_MASK  = 8'h03;
   localparam logic [7:0] ADDR_PCAP_ARM    = 8'h04;
   localparam logic [7:0] ADDR_PCAP_DISARM = 8'h05;
   localparam logic [7:0] ADDR_IRQ_STATUS  = 8'h08;
   localparam logic [7:0] ADDR_PCAP_DATA   = 8'h10;

   localparam int FLAG_ARMED    = 0;
   localparam int FLAG_DONE     = 1;
   localparam int FLAG_OVERFLOW = 2;
   localparam int FLAG_DISARMED = 3;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_ARMED = 1'b1
   } pcap_state_e;

endpackage

// File: rtl/pcap_fifo.sv
// Sample buffer for position capture: synchronous FIFO with flush and
// same-cycle push/pop (a push into a full FIFO is accepted only alongside a pop).
module pcap_fifo #(
   parameter int DEPTH = 32,
   parameter int DW    = 32
) (
   input  logic          clk_sys,
   input  logic          rst_b,
   input  logic          flush,
   input  logic          push,
   input  logic [DW-1:0] push_data,
   input  logic          pop,
   output logic [DW-1:0] pop_data,
   output logic          full,
   output logic          empty
);
   localparam int PW = $clog2(DEPTH);

   logic [DW-1:0] mem_q [DEPTH];
   logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
   logic [PW:0]   cnt_q, cnt_d;
   logic          do_push, do_pop;

   assign full     = (cnt_q == (PW+1)'(DEPTH));
   assign empty    = (cnt_q == '0);
   assign do_pop   = pop && !empty;
   assign do_push  = push && (!full || do_pop);
   assign pop_data = mem_q[rp_q];

   always_comb begin
      wp_d  = wp_q;
      rp_d  = rp_q;
      cnt_d = cnt_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
      if (do_push) wp_d = (wp_q == PW'(DEPTH - 1)) ? '0 : wp_q + PW'(1);
      if (do_pop)  rp_d = (rp_q == PW'(DEPTH - 1)) ? '0 : rp_q + PW'(1);
      if (flush) begin
         wp_d  = '0;
         rp_d  = '0;
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk_sys) begin
      if (!rst_b) begin
         wp_q  <= '0;
         rp_q  <= '0;
         cnt_q <= '0;
      end else begin
         wp_q  <= wp_d;
         rp_q  <= rp_d;
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk_sys) begin
      if (do_push && !flush) mem_q[wp_q] <= push_data;
   end

endmodule

// File: rtl/panda_top_tb.sv
// PandA carrier harness: TTL synchroniser, PGEN table, PCAP capture engine and
// IRQ flags behind a word-addressed register bus.
//
// state    | meaning
// ST_IDLE  | not capturing; arm accepted when the table is non-empty
// ST_ARMED | each cycle the gate condition holds, one table entry is captured
module panda_top_tb
   import panda_tb_pkg::*;
#(
   parameter int TABLE_DEPTH = DEF_TABLE_DEPTH,
   parameter int BUF_DEPTH   = DEF_BUF_DEPTH,
   parameter int AW          = DEF_AW
) (
   input  logic          FCLK,
   input  logic          tb_ARESETn,
   input  logic [5:0]    ttlin_pad,
   input  logic          reg_wr,
   input  logic          reg_rd,
   input  logic [AW-1:0] reg_addr,
   input  logic [31:0]   reg_wdata,
   output logic [31:0]   reg_rdata,
   output logic          reg_rvalid,
   output logic          irq
);
   localparam int PW = $clog2(TABLE_DEPTH + 1);
   localparam int IW = $clog2(TABLE_DEPTH);

   logic [5:0]    ttl_meta_q, ttl_sync_q;
   logic [31:0]   table_q [TABLE_DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [31:0]   repeat_q, repeat_d, rpt_eff;
   logic [5:0]    mask_q, mask_d;
   pcap_state_e   state_q, state_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [31:0]   rpt_q, rpt_d;
   logic [15:0]   count_q, count_d;
   logic [7:0]    flags_q, flags_d, flags_set;
   logic          irq_q;
   logic [31:0]   rdata_q, rdata_d;
   logic          rvalid_q;

   logic wr_table, wr_pgen_reset, wr_repeat, wr_mask, wr_arm, wr_disarm;
   logic rd_status, rd_data, tbl_we;
   logic arm_go, cap_try, cap, ovf, last_idx, done;
   logic [31:0] fifo_head;
   logic fifo_full, fifo_empty;

   assign wr_table      = reg_wr && (reg_addr == AW'(ADDR_PGEN_TABLE));
   assign wr_pgen_reset = reg_wr && (reg_addr == AW'(ADDR_PGEN_RESET));
   assign wr_repeat     = reg_wr && (reg_addr == AW'(ADDR_PGEN_REPEAT));
   assign wr_mask       = reg_wr && (reg_addr == AW'(ADDR_FRAME_MASK));
   assign wr_arm        = reg_wr && (reg_addr == AW'(ADDR_PCAP_ARM));
   assign wr_disarm     = reg_wr && (reg_addr == AW'(ADDR_PCAP_DISARM));
   assign rd_status     = reg_rd && (reg_addr == AW'(ADDR_IRQ_STATUS));
   assign rd_data       = reg_rd && (reg_addr == AW'(ADDR_PCAP_DATA));
   assign tbl_we        = wr_table && (wr_ptr_q != PW'(TABLE_DEPTH));

   assign arm_go   = wr_arm && (state_q == ST_IDLE) && (wr_ptr_q != '0);
   assign cap_try  = (state_q == ST_ARMED) && ((ttl_sync_q & mask_q) == mask_q);
   assign ovf      = cap_try && fifo_full;
   assign cap      = cap_try && !fifo_full;
   assign rpt_eff  = (repeat_q == '0) ? 32'd1 : repeat_q;
   assign last_idx = (idx_q == IW'(wr_ptr_q - PW'(1)));
   assign done     = cap && last_idx && (rpt_q == rpt_eff - 32'd1);

   pcap_fifo #(.DEPTH(BUF_DEPTH), .DW(32)) u_fifo (
      .clk_sys   (FCLK),
      .rst_b     (tb_ARESETn),
      .flush     (arm_go),
      .push      (cap),
      .push_data (table_q[idx_q]),
      .pop       (rd_data),
      .pop_data  (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   always_ff @(posedge FCLK) begin
      if (!tb_ARESETn) state_q <= ST_IDLE;
      else             state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (arm_go) state_d = ST_ARMED;
         ST_ARMED: if (ovf || done || wr_disarm) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // A flag raised in the same cycle as an IRQ_STATUS read survives the clear.
   always_comb begin
      idx_d     = idx_q;
      rpt_d     = rpt_q;
      count_d   = count_q;
      flags_set = '0;
      if (arm_go) begin
         idx_d   = '0;
         rpt_d   = '0;
         count_d = '0;
         flags_set[FLAG_ARMED] = 1'b1;
      end
      if (cap) begin
         count_d = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
         if (last_idx) begin
            idx_d = '0;
            rpt_d = rpt_q + 32'd1;
         end else begin
            idx_d = idx_q + IW'(1);
         end
      end
      if (done) flags_set[FLAG_DONE]     = 1'b1;
      if (ovf)  flags_set[FLAG_OVERFLOW] = 1'b1;
      if (wr_disarm && (state_q == ST_ARMED)) flags_set[FLAG_DISARMED] = 1'b1;
      flags_d = (rd_status ? 8'h00 : flags_q) | flags_set;
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      repeat_d = repeat_q;
      mask_d   = mask_q;
      if (tbl_we)        wr_ptr_d = wr_ptr_q + PW'(1);
      if (wr_pgen_reset) wr_ptr_d = '0;
      if (wr_repeat)     repeat_d = reg_wdata;
      if (wr_mask)       mask_d   = reg_wdata[5:0];
      rdata_d = '0;
      if (reg_rd) begin
         case (reg_addr)
            AW'(ADDR_PGEN_REPEAT): rdata_d = repeat_q;
            AW'(ADDR_FRAME_MASK):  rdata_d = {26'd0, mask_q};
            AW'(ADDR_IRQ_STATUS):  rdata_d = {count_q, 8'h00, flags_q};
            AW'(ADDR_PCAP_DATA):   rdata_d = fifo_empty ? 32'd0 : fifo_head;
            default:               rdata_d = '0;
         endcase
      end
   end

   always_ff @(posedge FCLK) begin
      if (!tb_ARESETn) begin
         ttl_meta_q <= '0;
         ttl_sync_q <= '0;
         wr_ptr_q   <= '0;
         repeat_q   <= 32'd1;
         mask_q     <= '0;
         idx_q      <= '0;
         rpt_q      <= '0;
         count_q    <= '0;
         flags_q    <= '0;
         irq_q      <= 1'b0;
         rdata_q    <= '0;
         rvalid_q   <= 1'b0;
      end else begin
         ttl_meta_q <= ttlin_pad;
         ttl_sync_q <= ttl_meta_q;
         wr_ptr_q   <= wr_ptr_d;
         repeat_q   <= repeat_d;
         mask_q     <= mask_d;
         idx_q      <= idx_d;
         rpt_q      <= rpt_d;
         count_q    <= count_d;
         flags_q    <= flags_d;
         irq_q      <= |flags_q;
         rdata_q    <= rdata_d;
         rvalid_q   <= reg_rd;
      end
   end

   always_ff @(posedge FCLK) begin
      if (tbl_we) table_q[wr_ptr_q[IW-1:0]] <= reg_wdata;
   end

   assign reg_rdata  = rdata_q;
   assign reg_rvalid = rvalid_q;
   assign irq        = irq_q;

endmodule

// File: tb/tb_panda_top_tb.sv
// End-to-end bench for the PandA carrier harness: register reads are scored
// against a queue of expected values filled from a transaction-level model.
module tb_panda_top_tb;
   import panda_tb_pkg::*;

   logic        FCLK = 1'b0;
   logic        tb_ARESETn = 1'b0;
   logic [5:0]  ttlin_pad = '0;
   logic        reg_wr = 1'b0;
   logic        reg_rd = 1'b0;
   logic [7:0]  reg_addr = '0;
   logic [31:0] reg_wdata = '0;
   logic [31:0] reg_rdata;
   logic        reg_rvalid;
   logic        irq;

   int n_vec = 0;
   int n_err = 0;

   logic [31:0] exp_q[$];
   string       name_q[$];

   // model state
   logic [31:0] m_tab[$];
   logic [31:0] m_buf[$];
   int          m_rep;
   int          m_cnt;
   logic [7:0]  m_flags;

   panda_top_tb dut (
      .FCLK       (FCLK),
      .tb_ARESETn (tb_ARESETn),
      .ttlin_pad  (ttlin_pad),
      .reg_wr     (reg_wr),
      .reg_rd     (reg_rd),
      .reg_addr   (reg_addr),
      .reg_wdata  (reg_wdata),
      .reg_rdata  (reg_rdata),
      .reg_rvalid (reg_rvalid),
      .irq        (irq)
   );

   always #5 FCLK = ~FCLK;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   always @(negedge FCLK) begin
      if (reg_rvalid === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_rvalid: got %h expected no read response", reg_rdata);
         end else begin
            check(name_q.pop_front(), reg_rdata, exp_q.pop_front());
         end
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) @(posedge FCLK);
      #1;
   endtask

   task automatic wr(input logic [7:0] a, input logic [31:0] d);
      reg_wr = 1'b1; reg_addr = a; reg_wdata = d;
      tick();
      reg_wr = 1'b0;
   endtask

   task automatic rd(input logic [7:0] a, input logic [31:0] exp, input string nm);
      exp_q.push_back(exp);
      name_q.push_back(nm);
      reg_rd = 1'b1; reg_addr = a;
      tick();
      reg_rd = 1'b0;
   endtask

   // Table write pointer saturates at the depth; surplus writes are dropped.
   task automatic write_table(input logic [31:0] words[$], input int rep);
      wr(ADDR_PGEN_RESET, 0);
      m_tab.delete();
      foreach (words[i]) begin
         wr(ADDR_PGEN_TABLE, words[i]);
         if (m_tab.size() < DEF_TABLE_DEPTH) m_tab.push_back(words[i]);
      end
      wr(ADDR_PGEN_REPEAT, rep);
      m_rep = (rep == 0) ? 1 : rep;
   endtask

   task automatic random_table(input int n, input int rep);
      logic [31:0] w[$];
      for (int i = 0; i < n; i++) w.push_back($urandom);
      write_table(w, rep);
   endtask

   // Arm with the gate always open: the captured stream is the table repeated,
   // cut off when the buffer runs out of room.
   function automatic void model_full_run();
      int total;
      total = m_tab.size() * m_rep;
      m_buf.delete();
      m_cnt = 0;
      m_flags = 8'h01;
      for (int k = 0; k < total; k++) begin
         if (m_buf.size() == DEF_BUF_DEPTH) begin
            m_flags |= 8'h04;
            return;
         end
         m_buf.push_back(m_tab[k % m_tab.size()]);
         m_cnt++;
      end
      m_flags |= 8'h02;
   endfunction

   task automatic drain(input string tag);
      rd(ADDR_IRQ_STATUS, {16'(m_cnt), 8'h00, m_flags}, {tag, "_status"});
      m_flags = 8'h00;
      rd(ADDR_IRQ_STATUS, {16'(m_cnt), 8'h00, 8'h00}, {tag, "_status_clr"});
      while (m_buf.size() > 0) rd(ADDR_PCAP_DATA, m_buf.pop_front(), {tag, "_data"});
      rd(ADDR_PCAP_DATA, 32'd0, {tag, "_data_empty"});
      tick(3);
      check({tag, "_irq_low"}, {31'd0, irq}, 32'd0);
   endtask

   task automatic run_full(input string tag);
      model_full_run();
      wr(ADDR_PCAP_ARM, 0);
      tick(m_buf.size() + 8);
      check({tag, "_irq"}, {31'd0, irq}, 32'd1);
      drain(tag);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] w[$];
      int cycles;

      tick(3);
      tb_ARESETn = 1'b1;
      tick();

      // reset state
      check("reset_irq", {31'd0, irq}, 32'd0);
      rd(ADDR_IRQ_STATUS, 32'd0, "reset_status");
      rd(ADDR_PCAP_DATA, 32'd0, "reset_data");
      rd(ADDR_PGEN_REPEAT, 32'd1, "reset_repeat");
      rd(ADDR_FRAME_MASK, 32'd0, "reset_mask");
      rd(8'h07, 32'd0, "unmapped");

      // arm with an empty table does nothing
      wr(ADDR_PCAP_ARM, 0);
      tick(5);
      rd(ADDR_IRQ_STATUS, 32'd0, "empty_arm_status");
      check("empty_arm_irq", {31'd0, irq}, 32'd0);

      // fixed table {1,2,3,4} twice
      w = '{32'd1, 32'd2, 32'd3, 32'd4};
      write_table(w, 2);
      wr(ADDR_FRAME_MASK, 0);
      run_full("basic");

      // 32-entry table, no reads: overflow on the 33rd capture
      random_table(32, 2);
      run_full("overflow");

      // gated capture stalls until the synchronised TTL input opens the gate
      ttlin_pad = 6'h00;
      random_table(4, 1);
      wr(ADDR_FRAME_MASK, 32'h01);
      wr(ADDR_PCAP_ARM, 0);
      tick(100);
      rd(ADDR_IRQ_STATUS, 32'h0000_0001, "stall_status");
      rd(ADDR_PCAP_DATA, 32'd0, "stall_empty");
      tick(2);
      ttlin_pad = 6'h01;
      cycles = 0;
      while (irq !== 1'b1 && cycles < 40) begin
         tick();
         cycles++;
      end
      n_vec++;
      if (cycles < 6 || cycles > 8) begin
         n_err++;
         $display("FAIL stall_latency: got %0d cycles to irq expected 6..8", cycles);
      end
      m_buf = m_tab;
      m_cnt = 4;
      m_flags = 8'h02;
      drain("stall");

      // three gated captures then disarm
      ttlin_pad = 6'h00;
      random_table(8, 1);
      wr(ADDR_PCAP_ARM, 0);
      tick(5);
      ttlin_pad = 6'h01;
      tick(3);
      ttlin_pad = 6'h00;
      tick(6);
      wr(ADDR_PCAP_DISARM, 0);
      m_buf = m_tab[0:2];
      m_cnt = 3;
      m_flags = 8'h09;
      drain("disarm");

      // pops interleaved with captures
      wr(ADDR_FRAME_MASK, 0);
      random_table(8, 4);
      model_full_run();
      wr(ADDR_PCAP_ARM, 0);
      tick();
      for (int i = 0; i < 10; i++) rd(ADDR_PCAP_DATA, m_buf.pop_front(), "concurrent_data");
      tick(30);
      drain("concurrent");

      // randomized tables, repeats and always-satisfied masks
      ttlin_pad = 6'h3F;
      for (int it = 0; it < 12; it++) begin
         random_table($urandom_range(1, 34), $urandom_range(0, 3));
         wr(ADDR_FRAME_MASK, $urandom_range(0, 63));
         run_full("rand");
      end

      // reset mid-capture clears everything including the table pointer
      ttlin_pad = 6'h00;
      wr(ADDR_FRAME_MASK, 0);
      random_table(16, 3);
      wr(ADDR_PCAP_ARM, 0);
      tick(5);
      tb_ARESETn = 1'b0;
      tick(2);
      tb_ARESETn = 1'b1;
      tick();
      check("midreset_irq", {31'd0, irq}, 32'd0);
      rd(ADDR_IRQ_STATUS, 32'd0, "midreset_status");
      rd(ADDR_PCAP_DATA, 32'd0, "midreset_data");
      wr(ADDR_PCAP_ARM, 0);
      tick(5);
      rd(ADDR_IRQ_STATUS, 32'd0, "midreset_arm_status");
      check("midreset_arm_irq", {31'd0, irq}, 32'd0);

      tick(4);
      if (exp_q.size() != 0) begin
         n_vec++;
         n_err++;
         $display("FAIL pending_reads: got %0d outstanding expected 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
